// File: rtl/panel_cursor_pkg.sv
// Shared scancodes, action encodings and repeat-FSM states for the front-panel
// cursor controller.
package panel_cursor_pkg;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_HOME  = 8'h6C;
  localparam logic [7:0] SC_END   = 8'h69;
  localparam logic [7:0] SC_D0    = 8'h45;
  localparam logic [7:0] SC_D1    = 8'h16;
  localparam logic [7:0] SC_D2    = 8'h1E;

  localparam logic [1:0] ACT_OFF  = 2'd0;
  localparam logic [1:0] ACT_ON   = 2'd1;
  localparam logic [1:0] ACT_DOWN = 2'd2;
  localparam logic [1:0] ACT_MOVE = 2'd3;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_PERIOD = 2'd2
  } rpt_state_e;

  function automatic logic is_arrow(input logic [7:0] code);
    return (code == SC_UP) || (code == SC_DOWN) ||
           (code == SC_LEFT) || (code == SC_RIGHT);
  endfunction

  function automatic logic is_nav(input logic [7:0] code);
    return is_arrow(code) || (code == SC_HOME) || (code == SC_END);
  endfunction

endpackage

// File: rtl/panel_cursor_key_repeat.sv
// Auto-repeat timer: after arm, ticks once after REPEAT_DELAY cycles and then
// every REPEAT_PERIOD cycles until cancel. Arm takes priority over cancel.
module key_repeat
  import panel_cursor_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 2_500_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arm,
  input  logic       cancel,
  output logic       tick,
  output rpt_state_e state
);

  rpt_state_e  state_q;
  logic [31:0] cnt_q;
  logic        tick_q;
  logic [31:0] limit;

  always_comb begin
    limit = (state_q == RPT_DELAY) ? 32'(REPEAT_DELAY) : 32'(REPEAT_PERIOD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (arm) begin
        state_q <= RPT_DELAY;
        cnt_q   <= '0;
      end else if (cancel) begin
        state_q <= RPT_IDLE;
        cnt_q   <= '0;
      end else if (state_q != RPT_IDLE) begin
        if (cnt_q + 32'd1 >= limit) begin
          tick_q  <= 1'b1;
          cnt_q   <= '0;
          state_q <= RPT_PERIOD;
        end else begin
          cnt_q <= cnt_q + 32'd1;
        end
      end
    end
  end

  assign tick  = tick_q;
  assign state = state_q;

endmodule

// File: rtl/panel_cursor.sv
// Front-panel cursor controller: turns PS/2 make/break events into a cursor
// position over a ragged switch grid plus a switch action code.
module panel_cursor
  import panel_cursor_pkg::*;
#(
  parameter int          ROWS           = 2,
  parameter int          COLS           = 16,
  parameter int          LAST_ROW_COLS  = 9,
  parameter int          ROW_STRIDE     = 16,
  parameter int          INDEX_W        = 5,
  parameter int          MOMENTARY_BASE = 18,
  parameter logic [(1<<INDEX_W)-1:0] LATCH_MASK = 32'h0180_0000,
  parameter int unsigned REPEAT_DELAY   = 25_000_000,
  parameter int unsigned REPEAT_PERIOD  = 2_500_000,
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [10:0]        ps2_key,
  input  logic               enable,
  output logic [ROW_W-1:0]   cursor_row,
  output logic [COL_W-1:0]   cursor_col,
  output logic [INDEX_W-1:0] cursor_index,
  output logic [1:0]         cursor_action,
  output logic               move_strobe
);

  logic               tog0_q, tog1_q, evt_q, evt_d;
  logic [1:0]         prime_q;
  logic [9:0]         key0_q, kev_q;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [1:0]         action_q, action_d;
  logic               strobe_q, strobe_d;
  logic [7:0]         rep_code_q, rep_code_d, mv_code;
  logic               arm, cancel, do_move, momentary, rep_tick;
  rpt_state_e         rep_state;
  int                 r, c, w;

  function automatic int row_width(input int row);
    return (row == ROWS - 1) ? LAST_ROW_COLS : COLS;
  endfunction

  // Events count only once the second stage holds a post-reset sample.
  assign evt_d = prime_q[1] & (tog0_q ^ tog1_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tog0_q  <= 1'b0;
      tog1_q  <= 1'b0;
      prime_q <= 2'b00;
      key0_q  <= '0;
      evt_q   <= 1'b0;
      kev_q   <= '0;
    end else begin
      tog0_q  <= ps2_key[10];
      tog1_q  <= tog0_q;
      prime_q <= {prime_q[0], 1'b1};
      key0_q  <= ps2_key[9:0];
      evt_q   <= evt_d;
      kev_q   <= key0_q;
    end
  end

  key_repeat #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_repeat (
    .clk   (clk),
    .rst_n (reset),
    .arm   (arm),
    .cancel(cancel),
    .tick  (rep_tick),
    .state (rep_state)
  );

  assign momentary = int'(index_q) >= MOMENTARY_BASE;

  always_comb begin
    row_d      = row_q;
    col_d      = col_q;
    action_d   = action_q;
    strobe_d   = 1'b0;
    rep_code_d = rep_code_q;
    mv_code    = kev_q[7:0];
    do_move    = 1'b0;
    arm        = 1'b0;
    cancel     = !enable;
    r          = int'(row_q);
    c          = int'(col_q);
    w          = row_width(r);

    // A fresh event always overrides a repeat tick in the same cycle.
    if (enable && evt_q) begin
      if (kev_q[8] && kev_q[9] && is_arrow(kev_q[7:0])) begin
        arm        = 1'b1;
        rep_code_d = kev_q[7:0];
      end else begin
        cancel = 1'b1;
      end
      if (kev_q[8] && kev_q[9] && is_nav(kev_q[7:0])) do_move = 1'b1;
      if (!kev_q[8] && kev_q[9]) begin
        case (kev_q[7:0])
          SC_D0:   action_d = ACT_OFF;
          SC_D1:   action_d = ACT_ON;
          SC_D2:   action_d = momentary ? ACT_DOWN : ACT_OFF;
          default: ;
        endcase
      end
      if (!kev_q[8] && !kev_q[9] && (kev_q[7:0] == SC_D1 || kev_q[7:0] == SC_D2) &&
          momentary && !LATCH_MASK[index_q]) begin
        action_d = ACT_OFF;
      end
    end else if (enable && rep_tick && rep_state != RPT_IDLE) begin
      do_move = 1'b1;
      mv_code = rep_code_q;
    end

    if (do_move) begin
      case (mv_code)
        SC_UP:    if (r > 0) r = r - 1;
        SC_DOWN:  if (r < ROWS - 1) r = r + 1;
        SC_LEFT:  c = (c == 0) ? w - 1 : c - 1;
        SC_RIGHT: c = (c >= w - 1) ? 0 : c + 1;
        SC_HOME:  c = 0;
        SC_END:   c = w - 1;
        default:  ;
      endcase
      w = row_width(r);
      if (c > w - 1) c = w - 1;
      row_d    = ROW_W'(r);
      col_d    = COL_W'(c);
      action_d = ACT_MOVE;
      strobe_d = 1'b1;
    end

    index_d = INDEX_W'(int'(row_d) * ROW_STRIDE + int'(col_d));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q      <= '0;
      col_q      <= '0;
      index_q    <= '0;
      action_q   <= ACT_OFF;
      strobe_q   <= 1'b0;
      rep_code_q <= '0;
    end else begin
      row_q      <= row_d;
      col_q      <= col_d;
      index_q    <= index_d;
      action_q   <= action_d;
      strobe_q   <= strobe_d;
      rep_code_q <= rep_code_d;
    end
  end

  assign cursor_row    = row_q;
  assign cursor_col    = col_q;
  assign cursor_index  = index_q;
  assign cursor_action = action_q;
  assign move_strobe   = strobe_q;

endmodule

// File: tb/tb_panel_cursor.sv
// Bench for panel_cursor: directed scenarios plus random key events checked
// against a grid-level cursor model.
module tb_panel_cursor;

  localparam int ROWS = 2, COLS = 16, LAST = 9, STRIDE = 16;
  localparam int D = 20, P = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] ps2_key = '0;
  logic        enable = 1'b1;
  logic [0:0]  cursor_row;
  logic [3:0]  cursor_col;
  logic [4:0]  cursor_index;
  logic [1:0]  cursor_action;
  logic        move_strobe;

  int checks = 0, failures = 0, strobe_cnt = 0;
  int m_row = 0, m_col = 0, m_act = 0, m_strobes = 0;
  logic [11:0] got, exp;

  panel_cursor #(
    .ROWS(ROWS), .COLS(COLS), .LAST_ROW_COLS(LAST), .ROW_STRIDE(STRIDE),
    .INDEX_W(5), .MOMENTARY_BASE(18), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .enable(enable),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .cursor_index(cursor_index), .cursor_action(cursor_action),
    .move_strobe(move_strobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (move_strobe === 1'b1) strobe_cnt++;

  // ---------------- reference model ----------------
  function automatic int m_width(input int row);
    return (row == ROWS - 1) ? LAST : COLS;
  endfunction

  function automatic logic [11:0] m_bundle();
    logic [11:0] b;
    int idx;
    idx = m_row * STRIDE + m_col;
    b = {1'(m_row), 4'(m_col), 5'(idx), 2'(m_act)};
    return b;
  endfunction

  task automatic model_event(input bit ext, input bit make, input logic [7:0] code);
    int idx, w;
    bit moved;
    idx = m_row * STRIDE + m_col;
    w = m_width(m_row);
    moved = 1'b1;
    if (ext && make) begin
      case (code)
        8'h75: m_row = (m_row > 0) ? m_row - 1 : 0;
        8'h72: m_row = (m_row < ROWS - 1) ? m_row + 1 : ROWS - 1;
        8'h6B: m_col = (m_col + w - 1) % w;
        8'h74: m_col = (m_col + 1) % w;
        8'h6C: m_col = 0;
        8'h69: m_col = w - 1;
        default: moved = 1'b0;
      endcase
      if (moved) begin
        if (m_col > m_width(m_row) - 1) m_col = m_width(m_row) - 1;
        m_act = 3;
        m_strobes++;
      end
    end else if (!ext && make) begin
      if (code == 8'h45) m_act = 0;
      else if (code == 8'h16) m_act = 1;
      else if (code == 8'h1E) m_act = (idx >= 18) ? 2 : 0;
    end else if (!ext && !make && (code == 8'h16 || code == 8'h1E)) begin
      if (idx >= 18 && !(idx == 23 || idx == 24)) m_act = 0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input bit ext, input bit make, input logic [7:0] code);
    @(negedge clk);
    ps2_key = {~ps2_key[10], make, ext, code};
    repeat (3) @(posedge clk);
    #1;
    if (enable) model_event(ext, make, code);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] code);
    send(1'b1, 1'b1, code);
    send(1'b1, 1'b0, code);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    got = {cursor_row, cursor_col, cursor_index, cursor_action};
    checks++;
    if (got !== 12'h000 || move_strobe !== 1'b0) begin
      $display("FAIL reset_held: got %h strobe %b exp 000 strobe 0", got, move_strobe);
      failures++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    got = {cursor_row, cursor_col, cursor_index, cursor_action};
    checks++;
    if (got !== 12'h000 || strobe_cnt !== 0) begin
      $display("FAIL reset_release: got %h strobes %0d exp 000 strobes 0", got, strobe_cnt);
      failures++;
    end
  endtask

  task automatic test_latency();
    @(negedge clk);
    ps2_key = {~ps2_key[10], 1'b1, 1'b1, 8'h74};
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cursor_col !== 4'd0 || move_strobe !== 1'b0) begin
      $display("FAIL latency_early: col %0d strobe %b exp col 0 strobe 0", cursor_col, move_strobe);
      failures++;
    end
    @(posedge clk);
    #1;
    model_event(1'b1, 1'b1, 8'h74);
    checks++;
    if (cursor_col !== 4'd1 || move_strobe !== 1'b1 || cursor_index !== 5'd1) begin
      $display("FAIL latency_third: col %0d idx %0d strobe %b exp col 1 idx 1 strobe 1",
               cursor_col, cursor_index, move_strobe);
      failures++;
    end
    repeat (2) @(posedge clk);
    send(1'b1, 1'b0, 8'h74);
  endtask

  task automatic test_right_wrap();
    int s0;
    press(8'h6C);
    for (int k = 1; k <= 17; k++) begin
      s0 = strobe_cnt;
      press(8'h74);
      got = {cursor_row, cursor_col, cursor_index, cursor_action};
      exp = m_bundle();
      checks++;
      if (got !== exp || cursor_col !== 4'(k % 16) || strobe_cnt - s0 !== 1) begin
        $display("FAIL right_wrap[%0d]: got %h col %0d strobes %0d exp %h col %0d strobes 1",
                 k, got, cursor_col, strobe_cnt - s0, exp, k % 16);
        failures++;
      end
    end
  endtask

  task automatic test_down_clamp();
    press(8'h6C);
    for (int k = 0; k < 12; k++) press(8'h74);
    for (int k = 0; k < 2; k++) begin
      press(8'h72);
      got = {cursor_row, cursor_col, cursor_index, cursor_action};
      exp = m_bundle();
      checks++;
      if (got !== exp || cursor_index !== 5'd24 || cursor_col !== 4'd8) begin
        $display("FAIL down_clamp[%0d]: got %h idx %0d exp %h idx 24", k, got, cursor_index, exp);
        failures++;
      end
    end
  endtask

  task automatic test_digits();
    logic [1:0] want [7];
    logic [7:0] code [7];
    bit         mk   [7];
    want = '{2'd2, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd1};
    code = '{8'h1E, 8'h1E, 8'h1E, 8'h1E, 8'h1E, 8'h16, 8'h16};
    mk   = '{1, 0, 1, 0, 1, 1, 0};
    press(8'h6C);
    press(8'h74);
    press(8'h74);
    for (int k = 0; k < 7; k++) begin
      if (k == 2) for (int j = 0; j < 5; j++) press(8'h74);
      if (k == 4) begin
        press(8'h75);
        press(8'h6B);
        press(8'h6B);
      end
      send(1'b0, mk[k], code[k]);
      got = {cursor_row, cursor_col, cursor_index, cursor_action};
      exp = m_bundle();
      checks++;
      if (got !== exp || cursor_action !== want[k]) begin
        $display("FAIL digit[%0d] idx %0d: got %h act %0d exp %h act %0d",
                 k, cursor_index, got, cursor_action, exp, want[k]);
        failures++;
      end
    end
  endtask

  task automatic test_ignored();
    int s0;
    s0 = strobe_cnt;
    exp = m_bundle();
    send(1'b0, 1'b1, 8'h74);
    send(1'b0, 1'b0, 8'h74);
    got = {cursor_row, cursor_col, cursor_index, cursor_action};
    checks++;
    if (got !== exp || strobe_cnt !== s0) begin
      $display("FAIL nonext_right: got %h strobes %0d exp %h strobes 0", got, strobe_cnt - s0, exp);
      failures++;
    end
    enable = 1'b0;
    send(1'b1, 1'b1, 8'h74);
    send(1'b1, 1'b1, 8'h72);
    send(1'b0, 1'b1, 8'h16);
    repeat (2) @(posedge clk);
    enable = 1'b1;
    repeat (D + 5) @(posedge clk);
    #1;
    got = {cursor_row, cursor_col, cursor_index, cursor_action};
    checks++;
    if (got !== exp || strobe_cnt !== s0) begin
      $display("FAIL disabled_drop: got %h strobes %0d exp %h strobes 0", got, strobe_cnt - s0, exp);
      failures++;
    end
  endtask

  task automatic test_random();
    logic [7:0] codes [10];
    logic [7:0] code;
    bit ext, make;
    int sel, s0, ms0;
    codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h6C, 8'h69, 8'h45, 8'h16, 8'h1E, 8'h00};
    s0 = strobe_cnt;
    ms0 = m_strobes;
    for (int k = 0; k < 80; k++) begin
      sel  = $urandom_range(0, 9);
      code = (sel == 9) ? 8'($urandom_range(0, 255)) : codes[sel];
      ext  = 1'($urandom_range(0, 1));
      make = 1'($urandom_range(0, 1));
      send(ext, make, code);
      got = {cursor_row, cursor_col, cursor_index, cursor_action};
      exp = m_bundle();
      checks++;
      if (got !== exp) begin
        $display("FAIL random[%0d] ext=%b make=%b code=%h: got %h exp %h", k, ext, make, code, got, exp);
        failures++;
      end
    end
    send(1'b0, 1'b0, 8'h45);
    checks++;
    if (strobe_cnt - s0 !== m_strobes - ms0) begin
      $display("FAIL random_strobes: got %0d exp %0d", strobe_cnt - s0, m_strobes - ms0);
      failures++;
    end
  endtask

  task automatic test_repeat();
    int s0;
    press(8'h6C);
    s0 = strobe_cnt;
    @(negedge clk);
    ps2_key = {~ps2_key[10], 1'b1, 1'b1, 8'h74};
    repeat (3) @(posedge clk);
    #1;
    repeat (D + 2 * P + 2) @(posedge clk);
    @(negedge clk);
    ps2_key = {~ps2_key[10], 1'b0, 1'b1, 8'h74};
    repeat (D + 3 * P) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) model_event(1'b1, 1'b1, 8'h74);
    got = {cursor_row, cursor_col, cursor_index, cursor_action};
    exp = m_bundle();
    checks++;
    if (strobe_cnt - s0 !== 4 || got !== exp) begin
      $display("FAIL repeat_hold: strobes %0d state %h exp strobes 4 state %h", strobe_cnt - s0, got, exp);
      failures++;
    end

    @(negedge clk);
    ps2_key = {~ps2_key[10], 1'b1, 1'b1, 8'h74};
    repeat (D + P + 3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    s0 = strobe_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    m_row = 0;
    m_col = 0;
    m_act = 0;
    repeat (3 * D) @(posedge clk);
    #1;
    got = {cursor_row, cursor_col, cursor_index, cursor_action};
    checks++;
    if (strobe_cnt !== s0 || got !== 12'h000) begin
      $display("FAIL repeat_reset: strobes %0d state %h exp strobes 0 state 000", strobe_cnt - s0, got);
      failures++;
    end
    send(1'b1, 1'b0, 8'h74);
    press(8'h74);
    got = {cursor_row, cursor_col, cursor_index, cursor_action};
    exp = m_bundle();
    checks++;
    if (got !== exp) begin
      $display("FAIL after_reset_move: got %h exp %h", got, exp);
      failures++;
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_right_wrap();
    test_down_clamp();
    test_digits();
    test_ignored();
    test_random();
    test_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
